// File: rtl/rv_ctrl_pkg.sv
// Shared control definitions for the five-stage pipeline: opcodes, store func3
// codes, stage control word with its bubble value, FSM states and ID decode.
package rv_ctrl_pkg;

    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_R_I    = 5'b00100;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_R_R    = 5'b01100;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_ECALL  = 5'b11100;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;
    localparam logic [2:0] F3_SD = 3'b011;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_HALT
    } ctrl_state_e;

    typedef struct packed {
        logic       is_load;
        logic       is_store;
        logic       is_branch;
        logic       is_jal;
        logic       is_jalr;
        logic       wb_en;
        logic       wb_sel;
        logic       alu_src1_sel;
        logic       alu_src2_sel;
        logic       jb_src1_sel;
        logic [2:0] func3;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    // ECALL and unknown opcodes decode to a bubble; the FSM detects ECALL separately.
    function automatic ctrl_t decode(input logic [4:0] opcode, input logic [2:0] func3,
                                     input logic rd_nz);
        ctrl_t c;
        c       = CTRL_BUBBLE;
        c.func3 = func3;
        case (opcode)
            OP_R_R:        begin c.wb_en = 1'b1; c.alu_src2_sel = 1'b1; end
            OP_R_I, OP_LUI: c.wb_en = 1'b1;
            OP_AUIPC:      begin c.wb_en = 1'b1; c.alu_src1_sel = 1'b1; end
            OP_LOAD:       begin c.is_load = 1'b1; c.wb_en = 1'b1; c.wb_sel = 1'b1; end
            OP_STORE:      c.is_store = 1'b1;
            OP_BRANCH:     begin c.is_branch = 1'b1; c.alu_src2_sel = 1'b1; end
            OP_JAL:        begin c.is_jal = 1'b1; c.wb_en = 1'b1; c.alu_src1_sel = 1'b1; end
            OP_JALR: begin
                c.is_jalr      = 1'b1;
                c.wb_en        = 1'b1;
                c.alu_src1_sel = 1'b1;
                c.jb_src1_sel  = 1'b1;
            end
            default:       c = CTRL_BUBBLE;
        endcase
        if (!rd_nz) c.wb_en = 1'b0;
        return c;
    endfunction

endpackage

// File: rtl/pipe_hazard_unit.sv
// Combinational RAW hazard detection and forwarding selects for the ID instruction.
// PIPE_CTRL_FORWARD_EN: forward from MEM/WB and stall only on load-use.
module pipe_hazard_unit #(
    parameter int unsigned REG_AW = 5
) (
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_wb_en,
    input  logic              ex_is_load,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_wb_en,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_wb_en,
    output logic              raw_stall,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b
);

    logic ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b, wb_hit_a, wb_hit_b;
    logic unused_sig;

    assign ex_hit_a  = id_use_rs1 && ex_wb_en  && (ex_rd  != '0) && (ex_rd  == id_rs1);
    assign ex_hit_b  = id_use_rs2 && ex_wb_en  && (ex_rd  != '0) && (ex_rd  == id_rs2);
    assign mem_hit_a = id_use_rs1 && mem_wb_en && (mem_rd != '0) && (mem_rd == id_rs1);
    assign mem_hit_b = id_use_rs2 && mem_wb_en && (mem_rd != '0) && (mem_rd == id_rs2);
    assign wb_hit_a  = id_use_rs1 && wb_wb_en  && (wb_rd  != '0) && (wb_rd  == id_rs1);
    assign wb_hit_b  = id_use_rs2 && wb_wb_en  && (wb_rd  != '0) && (wb_rd  == id_rs2);

`ifdef PIPE_CTRL_FORWARD_EN
    // Selects are computed one stage early: an EX writer is in MEM when this
    // instruction reaches EX, a MEM writer is in WB.
    assign raw_stall  = ex_is_load && (ex_hit_a || ex_hit_b);
    assign fwd_a      = ex_hit_a ? 2'b01 : (mem_hit_a ? 2'b10 : 2'b00);
    assign fwd_b      = ex_hit_b ? 2'b01 : (mem_hit_b ? 2'b10 : 2'b00);
    assign unused_sig = &{1'b0, wb_hit_a, wb_hit_b};
`else
    assign raw_stall  = |{ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b, wb_hit_a, wb_hit_b};
    assign fwd_a      = 2'b00;
    assign fwd_b      = 2'b00;
    assign unused_sig = &{1'b0, ex_is_load};
`endif

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Five-stage pipeline control: ID decode, ID/EX-EX/MEM-MEM/WB control registers,
// redirect/stall handling and ECALL drain-and-halt. Forwarding via PIPE_CTRL_FORWARD_EN.
module pipe_ctrl_unit
    import rv_ctrl_pkg::*;
#(
    parameter int unsigned DM_BE_W = 4,
    parameter int unsigned REG_AW  = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [4:0]                 id_opcode,
    input  logic [2:0]                 id_func3,
    input  logic                       id_func7,
    input  logic [REG_AW-1:0]          id_rs1,
    input  logic [REG_AW-1:0]          id_rs2,
    input  logic [REG_AW-1:0]          id_rd,
    input  logic                       ex_alu_branch,
    input  logic [$clog2(DM_BE_W)-1:0] ex_addr_lo,
    output logic                       stall,
    output logic                       flush,
    output logic                       next_pc_sel,
    output logic                       ex_alu_src1_sel,
    output logic                       ex_alu_src2_sel,
    output logic                       ex_jb_src1_sel,
    output logic [1:0]                 fwd_a_sel,
    output logic [1:0]                 fwd_b_sel,
    output logic [DM_BE_W-1:0]         mem_dm_w_en,
    output logic                       mem_misalign,
    output logic                       wb_en,
    output logic                       wb_sel,
    output logic [REG_AW-1:0]          wb_rd,
    output logic                       halt
);

    localparam int unsigned OFF_W = $clog2(DM_BE_W);

    ctrl_t             id_ctrl, ex_ctrl_d, ex_ctrl_q;
    logic              id_use_rs1, id_use_rs2, raw_stall, taken, id_bubble;
    logic [1:0]        fwd_a_id, fwd_b_id, fwd_a_d, fwd_a_q, fwd_b_d, fwd_b_q;
    logic [REG_AW-1:0] ex_rd_d, ex_rd_q, mem_rd_q, wb_rd_q;
    logic              mem_wb_en_q, mem_wb_sel_q, mem_mis_q, wb_en_q, wb_sel_q;
    logic [DM_BE_W-1:0] st_base, st_be, mem_be_q;
    logic [OFF_W-1:0]  st_mask;
    logic              st_mis;
    ctrl_state_e       state_d, state_q;
    logic [1:0]        cnt_d, cnt_q;
    logic              unused_func7;

    assign unused_func7 = &{1'b0, id_func7};
    assign id_ctrl      = decode(id_opcode, id_func3, id_rd != '0);

    always_comb begin
        id_use_rs1 = 1'b0;
        id_use_rs2 = 1'b0;
        case (id_opcode)
            OP_R_R, OP_STORE, OP_BRANCH: begin id_use_rs1 = 1'b1; id_use_rs2 = 1'b1; end
            OP_R_I, OP_LOAD, OP_JALR:    id_use_rs1 = 1'b1;
            default: ;
        endcase
    end

    pipe_hazard_unit #(.REG_AW(REG_AW)) u_hazard (
        .id_rs1    (id_rs1),
        .id_rs2    (id_rs2),
        .id_use_rs1(id_use_rs1),
        .id_use_rs2(id_use_rs2),
        .ex_rd     (ex_rd_q),
        .ex_wb_en  (ex_ctrl_q.wb_en),
        .ex_is_load(ex_ctrl_q.is_load),
        .mem_rd    (mem_rd_q),
        .mem_wb_en (mem_wb_en_q),
        .wb_rd     (wb_rd_q),
        .wb_wb_en  (wb_en_q),
        .raw_stall (raw_stall),
        .fwd_a     (fwd_a_id),
        .fwd_b     (fwd_b_id)
    );

    assign taken = (ex_ctrl_q.is_branch && ex_alu_branch) || ex_ctrl_q.is_jal || ex_ctrl_q.is_jalr;

    always_comb begin
        stall     = 1'b0;
        id_bubble = 1'b0;
        state_d   = state_q;
        cnt_d     = cnt_q;
        case (state_q)
            ST_RUN: begin
                stall     = raw_stall && !taken;
                id_bubble = raw_stall || taken;
                if (id_opcode == OP_ECALL && !taken && !raw_stall) begin
                    state_d = ST_DRAIN;
                    cnt_d   = 2'd3;
                end
            end
            ST_DRAIN: begin
                stall     = 1'b1;
                id_bubble = 1'b1;
                cnt_d     = cnt_q - 2'd1;
                if (cnt_q == 2'd1) state_d = ST_HALT;
            end
            ST_HALT: begin
                stall     = 1'b1;
                id_bubble = 1'b1;
            end
            default: state_d = ST_RUN;
        endcase
        ex_ctrl_d = id_bubble ? CTRL_BUBBLE : id_ctrl;
        ex_rd_d   = id_bubble ? '0 : id_rd;
        fwd_a_d   = id_bubble ? 2'b00 : fwd_a_id;
        fwd_b_d   = id_bubble ? 2'b00 : fwd_b_id;
    end

    always_comb begin
        st_base = '0;
        st_mask = '0;
        if (ex_ctrl_q.is_store) begin
            case (ex_ctrl_q.func3)
                F3_SB: st_base = DM_BE_W'(1);
                F3_SH: begin st_base = DM_BE_W'(3);  st_mask = OFF_W'(1); end
                F3_SW: begin st_base = DM_BE_W'(15); st_mask = OFF_W'(3); end
                F3_SD: if (DM_BE_W == 8) begin st_base = '1; st_mask = OFF_W'(7); end
                default: ;
            endcase
        end
        st_mis = (st_base != '0) && ((ex_addr_lo & st_mask) != '0);
        st_be  = st_mis ? '0 : (st_base << ex_addr_lo);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_RUN;
            cnt_q        <= 2'd3;
            ex_ctrl_q    <= CTRL_BUBBLE;
            ex_rd_q      <= '0;
            fwd_a_q      <= 2'b00;
            fwd_b_q      <= 2'b00;
            mem_wb_en_q  <= 1'b0;
            mem_wb_sel_q <= 1'b0;
            mem_rd_q     <= '0;
            mem_be_q     <= '0;
            mem_mis_q    <= 1'b0;
            wb_en_q      <= 1'b0;
            wb_sel_q     <= 1'b0;
            wb_rd_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ex_ctrl_q    <= ex_ctrl_d;
            ex_rd_q      <= ex_rd_d;
            fwd_a_q      <= fwd_a_d;
            fwd_b_q      <= fwd_b_d;
            mem_wb_en_q  <= ex_ctrl_q.wb_en;
            mem_wb_sel_q <= ex_ctrl_q.wb_sel;
            mem_rd_q     <= ex_rd_q;
            mem_be_q     <= st_be;
            mem_mis_q    <= st_mis;
            wb_en_q      <= mem_wb_en_q;
            wb_sel_q     <= mem_wb_sel_q;
            wb_rd_q      <= mem_rd_q;
        end
    end

    assign flush           = taken;
    assign next_pc_sel     = taken;
    assign ex_alu_src1_sel = ex_ctrl_q.alu_src1_sel;
    assign ex_alu_src2_sel = ex_ctrl_q.alu_src2_sel;
    assign ex_jb_src1_sel  = ex_ctrl_q.jb_src1_sel;
    assign fwd_a_sel       = fwd_a_q;
    assign fwd_b_sel       = fwd_b_q;
    assign mem_dm_w_en     = mem_be_q;
    assign mem_misalign    = mem_mis_q;
    assign wb_en           = wb_en_q;
    assign wb_sel          = wb_sel_q;
    assign wb_rd           = wb_rd_q;
    assign halt            = (state_q == ST_HALT);

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed self-checking bench for pipe_ctrl_unit (default DM_BE_W=4, REG_AW=5);
// expectations follow PIPE_CTRL_FORWARD_EN when it is defined for the build.
module tb_pipe_ctrl_unit;

    localparam logic [4:0] LOAD = 5'b00000, R_I = 5'b00100, STORE = 5'b01000, R_R = 5'b01100;
    localparam logic [4:0] BRANCH = 5'b11000, JALR = 5'b11001, JAL = 5'b11011, ECALL = 5'b11100;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] id_opcode;
    logic [2:0] id_func3;
    logic       id_func7;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       ex_alu_branch;
    logic [1:0] ex_addr_lo;
    logic       stall, flush, next_pc_sel, ex_alu_src1_sel, ex_alu_src2_sel, ex_jb_src1_sel;
    logic [1:0] fwd_a_sel, fwd_b_sel;
    logic [3:0] mem_dm_w_en;
    logic       mem_misalign, wb_en, wb_sel, halt;
    logic [4:0] wb_rd;

    int checks = 0;
    int errors = 0;

    pipe_ctrl_unit #(.DM_BE_W(4), .REG_AW(5)) dut (
        .clk(clk), .rst(rst),
        .id_opcode(id_opcode), .id_func3(id_func3), .id_func7(id_func7),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .ex_alu_branch(ex_alu_branch), .ex_addr_lo(ex_addr_lo),
        .stall(stall), .flush(flush), .next_pc_sel(next_pc_sel),
        .ex_alu_src1_sel(ex_alu_src1_sel), .ex_alu_src2_sel(ex_alu_src2_sel),
        .ex_jb_src1_sel(ex_jb_src1_sel), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .mem_dm_w_en(mem_dm_w_en), .mem_misalign(mem_misalign),
        .wb_en(wb_en), .wb_sel(wb_sel), .wb_rd(wb_rd), .halt(halt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic id_set(input logic [4:0] op, input logic [2:0] f3, input logic f7,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
        id_opcode = op; id_func3 = f3; id_func7 = f7;
        id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        #1;
    endtask

    task automatic nop();
        id_set(R_I, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0);
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        ex_alu_branch = 1'b0;
        ex_addr_lo    = 2'd0;
        nop();
        rst = 1'b1;
        tick();
        check("reset_ctrl", {stall, flush, next_pc_sel, ex_alu_src1_sel, ex_alu_src2_sel,
                             ex_jb_src1_sel, wb_en, wb_sel}, 8'h00);
        check("reset_fwd", {fwd_a_sel, fwd_b_sel}, 8'h00);
        check("reset_mem", {mem_misalign, mem_dm_w_en}, 8'h00);
        check("reset_wb_rd_halt", {halt, wb_rd}, 8'h00);
        rst = 1'b0;
        tick();

        // Stores: SW @0, SB @2, SH @1 (misaligned)
        id_set(STORE, 3'b010, 1'b0, 5'd1, 5'd2, 5'd0);
        tick();
        check("sw_ex_src2_imm", ex_alu_src2_sel, 8'd0);
        ex_addr_lo = 2'd0;
        id_set(STORE, 3'b000, 1'b0, 5'd1, 5'd2, 5'd0);
        tick();
        check("sw_be", mem_dm_w_en, 8'h0F);
        check("sw_mis", mem_misalign, 8'd0);
        ex_addr_lo = 2'd2;
        id_set(STORE, 3'b001, 1'b0, 5'd1, 5'd2, 5'd0);
        tick();
        check("sb_be", mem_dm_w_en, 8'h04);
        check("sb_mis", mem_misalign, 8'd0);
        ex_addr_lo = 2'd1;
        nop();
        tick();
        check("sh_be", mem_dm_w_en, 8'h00);
        check("sh_mis", mem_misalign, 8'd1);
        ex_addr_lo = 2'd0;
        tick();
        check("bubble_mis", mem_misalign, 8'd0);

        // add x7,x1,x2 through to WB
        id_set(R_R, 3'b000, 1'b0, 5'd1, 5'd2, 5'd7);
        tick();
        check("add_ex_sel", {ex_alu_src1_sel, ex_alu_src2_sel, ex_jb_src1_sel}, 8'b010);
        nop();
        tick();
        tick();
        check("add_wb", {wb_en, wb_sel}, 8'b10);
        check("add_wb_rd", wb_rd, 8'd7);

        // lw x5,0(x1) ; add x6,x5,x2
        id_set(LOAD, 3'b010, 1'b0, 5'd1, 5'd0, 5'd5);
        tick();
        id_set(R_R, 3'b000, 1'b0, 5'd5, 5'd2, 5'd6);
        check("lu_stall", {stall, flush}, 8'b10);
        tick();
`ifdef PIPE_CTRL_FORWARD_EN
        check("lu_stall_once", stall, 8'd0);
        check("lu_ex_bubble", ex_alu_src2_sel, 8'd0);
        tick();
        check("lu_fwd", {fwd_a_sel, fwd_b_sel}, 8'b1000);
`else
        check("raw_stall_mem", stall, 8'd1);
        tick();
        check("raw_stall_wb", stall, 8'd1);
        check("lw_wb", {wb_en, wb_sel, wb_rd}, {2'b11, 5'd5});
        tick();
        check("raw_release", stall, 8'd0);
        tick();
        check("nofwd_fwd", {fwd_a_sel, fwd_b_sel}, 8'b0000);
`endif
        check("lu_add_in_ex", ex_alu_src2_sel, 8'd1);
        nop();
        repeat (4) tick();

        // Taken branch while the ID instruction has a hazard on a pending load
        id_set(LOAD, 3'b010, 1'b0, 5'd1, 5'd0, 5'd5);
        tick();
        id_set(BRANCH, 3'b000, 1'b0, 5'd1, 5'd2, 5'd0);
        check("beq_no_stall", stall, 8'd0);
        tick();
        ex_alu_branch = 1'b1;
        id_set(R_R, 3'b000, 1'b0, 5'd5, 5'd2, 5'd6);
        check("br_flush_prio", {next_pc_sel, flush, stall}, 8'b110);
        tick();
        ex_alu_branch = 1'b0;
        nop();
        check("br_bubble", {ex_alu_src2_sel, next_pc_sel, flush}, 8'b000);
        id_set(BRANCH, 3'b000, 1'b0, 5'd1, 5'd2, 5'd0);
        tick();
        nop();
        check("br_not_taken", {next_pc_sel, flush, ex_alu_src2_sel}, 8'b001);
        repeat (4) tick();

        // jalr x1,0(x2) then jal x0
        id_set(JALR, 3'b000, 1'b0, 5'd2, 5'd0, 5'd1);
        tick();
        nop();
        check("jalr_redirect", {next_pc_sel, flush}, 8'b11);
        check("jalr_sel", {ex_alu_src1_sel, ex_alu_src2_sel, ex_jb_src1_sel}, 8'b101);
        tick();
        check("jalr_bubble", {ex_alu_src1_sel, next_pc_sel}, 8'b00);
        tick();
        check("jalr_wb", {wb_en, wb_sel, wb_rd}, {2'b10, 5'd1});
        id_set(JAL, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0);
        tick();
        nop();
        check("jal_redirect", {next_pc_sel, ex_alu_src1_sel}, 8'b11);
        repeat (4) tick();

        // addi x0,x0,1 ; add x3,x0,x0
        id_set(R_I, 3'b000, 1'b0, 5'd0, 5'd1, 5'd0);
        tick();
        id_set(R_R, 3'b000, 1'b0, 5'd0, 5'd0, 5'd3);
        check("x0_no_stall", stall, 8'd0);
        tick();
        nop();
        check("x0_fwd", {fwd_a_sel, fwd_b_sel, stall}, 8'b00000);
        tick();
        check("x0_wb_en", wb_en, 8'd0);
        tick();
        check("add_x3_wb", {wb_en, wb_rd}, {1'b1, 5'd3});
        repeat (3) tick();

        // add x5,x1,x2 ; sub x6,x5,x3
        id_set(R_R, 3'b000, 1'b0, 5'd1, 5'd2, 5'd5);
        tick();
        id_set(R_R, 3'b000, 1'b1, 5'd5, 5'd3, 5'd6);
`ifdef PIPE_CTRL_FORWARD_EN
        check("alu_no_stall", stall, 8'd0);
        tick();
        check("alu_fwd_mem", {fwd_a_sel, fwd_b_sel}, 8'b0100);
`else
        check("raw_stall_1", stall, 8'd1);
        tick();
        check("raw_stall_2", stall, 8'd1);
        tick();
        check("raw_stall_3", stall, 8'd1);
        tick();
        check("raw_stall_end", stall, 8'd0);
        tick();
        check("sub_fwd_tied", {fwd_a_sel, fwd_b_sel}, 8'b0000);
`endif
        check("sub_in_ex", ex_alu_src2_sel, 8'd1);
        nop();
        repeat (4) tick();

        // ECALL squashed by a jump in EX
        id_set(JAL, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0);
        tick();
        id_set(ECALL, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0);
        check("ecall_sq_flush", flush, 8'd1);
        tick();
        nop();
        check("ecall_sq_run", stall, 8'd0);
        repeat (4) tick();
        check("ecall_sq_no_halt", {halt, stall}, 8'b00);

        // ECALL drain and halt, then reset
        id_set(ECALL, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0);
        check("ecall_id_stall", stall, 8'd0);
        tick();
        id_set(R_R, 3'b000, 1'b0, 5'd1, 5'd2, 5'd9);
        check("drain1", {halt, stall}, 8'b01);
        tick();
        check("drain2", {halt, stall}, 8'b01);
        tick();
        check("drain3", {halt, stall}, 8'b01);
        tick();
        check("halt_rise", {halt, stall, wb_en}, 8'b110);
        tick();
        check("halt_hold", {halt, wb_en, ex_alu_src2_sel}, 8'b100);
        rst = 1'b1;
        #1;
        check("halt_async_rst", {halt, stall}, 8'b00);
        rst = 1'b0;
        tick();
        check("post_rst_run", {halt, stall, ex_alu_src2_sel}, 8'b001);

        // Reset arriving mid-drain
        nop();
        tick();
        id_set(ECALL, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0);
        tick();
        nop();
        check("drain_again", stall, 8'd1);
        rst = 1'b1;
        #1;
        check("drain_async_rst", stall, 8'd0);
        rst = 1'b0;
        repeat (4) tick();
        check("drain_rst_no_halt", {halt, stall}, 8'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl_unit.md
# pipe_ctrl_unit

Pipelined control unit for the five-stage RV32/RV64 core. It decodes in ID and carries control through ID/EX, EX/MEM and MEM/WB registers. It also owns hazard handling: load-use stall, taken-branch/jump flush, optional forwarding selects, and an ECALL drain-and-halt sequence. Store byte enables are generated from the EX address offset and the store width.

## Interface
Parameters:
- DM_BE_W, default 4: data-memory byte-enable width; legal values 4 (32-bit) or 8 (64-bit, adds SD).
- REG_AW, default 5: register-index width.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_opcode  in  5  instr[6:2].
- id_func3  in  3  instr[14:12].
- id_func7  in  1  instr[30].
- id_rs1, id_rs2, id_rd  in  REG_AW each  ID-stage register indices.
- ex_alu_branch  in  1  branch-condition result from the EX ALU.
- ex_addr_lo  in  $clog2(DM_BE_W)  low bits of the EX effective address.
- stall  out  1  hold PC and IF/ID.
- flush  out  1  squash IF/ID.
- next_pc_sel  out  1  1 means the PC takes the jump/branch target.
- ex_alu_src1_sel  out  1  1 selects PC, 0 selects rs1.
- ex_alu_src2_sel  out  1  1 selects rs2, 0 selects imm.
- ex_jb_src1_sel  out  1  1 selects rs1 (JALR), 0 selects PC.
- fwd_a_sel, fwd_b_sel  out  2 each  00 selects RF, 01 selects MEM result, 10 selects WB result.
- mem_dm_w_en  out  DM_BE_W  shifted store byte enables.
- mem_misalign  out  1  store misaligned; enables forced to 0.
- wb_en  out  1  register-file write.
- wb_sel  out  1  1 selects load data.
- wb_rd  out  REG_AW  destination register.
- halt  out  1  core halted.

## Operation
- Decode in ID is combinational. A bubble is all-zero control: no write, no store, not a branch.
- wb_en is 1 for R_R, R_I, LOAD, JALR, LUI, AUIPC and JAL, and is forced to 0 when rd==0.
- Store base enables:
  - SB → 0x1.
  - SH → 0x3.
  - SW → 0xF.
  - SD → 0xFF (DM_BE_W=8 only).
  - Any other func3 → 0.
- In EX, the base enables are shifted left by ex_addr_lo.
  - Misalignment means the offset is not a multiple of the access size.
  - A misaligned store sets enables to 0 and mem_misalign=1 in MEM.
- next_pc_sel = (EX is BRANCH & ex_alu_branch) | EX is JAL | EX is JALR.
- Taken redirect: flush=1 in the same cycle, and ID/EX loads a bubble on the next edge.
- Load-use stall:
  - Condition: EX is LOAD, EX rd≠0, and EX rd matches an rs that the ID instruction actually uses. U/J types use no rs; R_I, LOAD and JALR use rs1 only.
  - Response: stall=1 for one cycle, and a bubble is inserted into ID/EX.
- Flush has priority over stall. When both are true, stall=0.
- FSM states: RUN, DRAIN, HALT.
  - RUN→DRAIN when ECALL is in ID with no flush and no stall that cycle. The ECALL itself enters EX as a bubble.
  - In DRAIN, stall=1, bubbles are injected, and a 2-bit counter runs 3→0. The counter reaching 0 goes to HALT.
  - In HALT, halt=1, stall=1, and all stage control stays a bubble. Only rst exits HALT.
  - An ECALL squashed by a flush is ignored.

## Timing
- ID decode is combinational to the ID/EX register. ex_* outputs are valid the cycle after ID.
- mem_* outputs are registered, one cycle after EX. wb_* outputs are one cycle after MEM.
- stall, flush and next_pc_sel are combinational from EX state and ID inputs, with no extra latency.
- halt rises 4 cycles after the ECALL cycle in ID (1 transition cycle plus 3 drain cycles).
- Reset state:
  - All stage registers are bubbles.
  - FSM=RUN, counter=3.
  - All outputs are 0.
- Reset asserted mid-stall or mid-drain takes effect immediately (asynchronous).

## Configuration
- PIPE_CTRL_FORWARD_EN defined:
  - fwd_a_sel/fwd_b_sel are driven. MEM match has priority over WB match, and rd==0 never matches.
  - Only load-use stalls occur.
- PIPE_CTRL_FORWARD_EN undefined:
  - fwd_* are tied to 00.
  - Any RAW match against an EX, MEM or WB writer with rd≠0 stalls until that writer leaves WB.

## Structure
- Shared package rv_ctrl_pkg holds:
  - 5-bit opcode constants: R_R, R_I, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, ECALL.
  - func3 store codes.
  - The FSM state enum.
  - The bubble constant.
- One sub-module, pipe_hazard_unit: a combinational stall/flush/forward computation from the ID indices and the EX/MEM/WB rd and wb_en values.

## Test plan
- SW with ex_addr_lo=0, then SB with ex_addr_lo=2, then SH with ex_addr_lo=1 → mem_dm_w_en 0xF, then 0x4, then 0x0 with mem_misalign=1.
- `lw x5,0(x1)` followed by `add x6,x5,x2` → stall=1 for exactly 1 cycle, one bubble in EX, then fwd_a_sel=10 (forwarding enabled).
- BRANCH with ex_alu_branch=1 while a load-use condition also exists → next_pc_sel=1, flush=1, stall=0, ID/EX bubble next cycle.
- ECALL in ID → stall from the next cycle, halt=1 four cycles later, wb_en=0 thereafter. A pulse of rst → halt=0 and FSM=RUN.
- `addi x0,x0,1` followed by `add x3,x0,x0` → wb_en=0, no stall, fwd_*=00.
- Build without PIPE_CTRL_FORWARD_EN: `add x5,x1,x2` followed by `sub x6,x5,x3` → stall=1 for 3 cycles, fwd_*=00.
